// File: rtl/err_stat_accum.sv
// Per-channel error statistics over a run of approximate/accurate sample pairs.
// Define ERRSTAT_MSE_EN to build the squared-error accumulator and saturation flags.
module err_stat_accum #(
  parameter int WIDTH  = 32,
  parameter int NCH    = 2,
  parameter int THRESH = 8,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*WIDTH-1:0]   appr,
  input  logic [NCH*WIDTH-1:0]   accu,
  input  logic [NCH*WIDTH-1:0]   comp,
  output logic                   busy,
  output logic                   done,
  output logic [NCH*ACC_W-1:0]   sum_err,
  output logic [NCH*ACC_W-1:0]   sum_sq,
  output logic [NCH*CNT_W-1:0]   nz_cnt,
  output logic [NCH*CNT_W-1:0]   hi_cnt,
  output logic [CNT_W-1:0]       smp_cnt,
  output logic [NCH-1:0]         sq_ovf
);

  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 4;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       drain_q, drain_d;
  logic [CNT_W-1:0]           num_q, num_d;
  logic [CNT_W-1:0]           acc_q, acc_d;
  logic                       start_acc, fire, last;

  logic                       s1_vld_q, s1_vld_d;
  logic [NCH-1:0][EW-1:0]     err_q, err_d;
  logic [NCH-1:0]             hi_q, hi_d;

  logic [NCH-1:0][ACC_W-1:0]  sum_err_q, sum_err_d;
  logic [NCH-1:0][CNT_W-1:0]  nz_q, nz_d;
  logic [NCH-1:0][CNT_W-1:0]  hic_q, hic_d;
  logic [CNT_W-1:0]           smp_q, smp_d;

  // Control FSM: RUN accepts exactly num_q samples, DRAIN covers the two-stage pipeline.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    num_d     = num_q;
    acc_d     = acc_q;
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    in_ready  = (state_q == S_RUN) && (acc_q < num_q);
    fire      = in_valid && in_ready;
    last      = fire && ((acc_q + CNT_W'(1)) == num_q);
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d   = num_samples;
          acc_d   = '0;
          state_d = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (fire) acc_d = acc_q + CNT_W'(1);
        if (last) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
      num_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    logic signed [EW-1:0] e;
    s1_vld_d  = fire;
    err_d     = err_q;
    hi_d      = hi_q;
    sum_err_d = sum_err_q;
    nz_d      = nz_q;
    hic_d     = hic_q;
    smp_d     = smp_q;
    e         = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (fire) begin
        err_d[ch] = {{2{appr[ch*WIDTH+WIDTH-1]}}, appr[ch*WIDTH +: WIDTH]}
                  - {{2{accu[ch*WIDTH+WIDTH-1]}}, accu[ch*WIDTH +: WIDTH]}
                  + {{2{comp[ch*WIDTH+WIDTH-1]}}, comp[ch*WIDTH +: WIDTH]};
        hi_d[ch]  = appr[ch*WIDTH+THRESH +: WIDTH-THRESH]
                 != accu[ch*WIDTH+THRESH +: WIDTH-THRESH];
      end
    end
    if (start_acc) begin
      sum_err_d = '0;
      nz_d      = '0;
      hic_d     = '0;
      smp_d     = '0;
    end else if (s1_vld_q) begin
      smp_d = smp_q + CNT_W'(1);
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        e             = err_q[ch];
        sum_err_d[ch] = sum_err_q[ch] + ACC_W'(e);
        if (e != '0) nz_d[ch]  = nz_q[ch] + CNT_W'(1);
        if (hi_q[ch]) hic_d[ch] = hic_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      err_q     <= '0;
      hi_q      <= '0;
      sum_err_q <= '0;
      nz_q      <= '0;
      hic_q     <= '0;
      smp_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      err_q     <= err_d;
      hi_q      <= hi_d;
      sum_err_q <= sum_err_d;
      nz_q      <= nz_d;
      hic_q     <= hic_d;
      smp_q     <= smp_d;
    end
  end

  assign sum_err = sum_err_q;
  assign nz_cnt  = nz_q;
  assign hi_cnt  = hic_q;
  assign smp_cnt = smp_q;

`ifdef ERRSTAT_MSE_EN
  logic [NCH-1:0][ACC_W-1:0] sum_sq_q, sum_sq_d;
  logic [NCH-1:0]            ovf_q, ovf_d;

  // Sum is formed one bit wider than both operands so saturation is an exact compare.
  always_comb begin
    logic signed [PW-1:0] ee;
    logic [PW-1:0]        prod;
    logic [SW-1:0]        sq_ext;
    sum_sq_d = sum_sq_q;
    ovf_d    = ovf_q;
    ee       = '0;
    prod     = '0;
    sq_ext   = '0;
    if (start_acc) begin
      sum_sq_d = '0;
      ovf_d    = '0;
    end else if (s1_vld_q) begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        ee     = PW'($signed(err_q[ch]));
        prod   = ee * ee;
        sq_ext = {{(SW-ACC_W){1'b0}}, sum_sq_q[ch]} + {{(SW-PW){1'b0}}, prod};
        if (sq_ext > {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}}) begin
          sum_sq_d[ch] = '1;
          ovf_d[ch]    = 1'b1;
        end else begin
          sum_sq_d[ch] = sq_ext[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_q <= '0;
      ovf_q    <= '0;
    end else begin
      sum_sq_q <= sum_sq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_sq = sum_sq_q;
  assign sq_ovf = ovf_q;
`else
  assign sum_sq = '0;
  assign sq_ovf = '0;
`endif

endmodule

// File: tb/tb_err_stat_accum.sv
// Directed self-checking bench for err_stat_accum (NCH=2, WIDTH=32, ACC_W=64).
module tb_err_stat_accum;

`ifdef ERRSTAT_MSE_EN
  localparam bit MSE = 1'b1;
`else
  localparam bit MSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   appr = '0, accu = '0, comp = '0;
  logic          busy, done;
  logic [127:0]  sum_err, sum_sq;
  logic [63:0]   nz_cnt, hi_cnt;
  logic [31:0]   smp_cnt;
  logic [1:0]    sq_ovf;

  int checks = 0;
  int failures = 0;

  err_stat_accum #(.WIDTH(32), .NCH(2), .THRESH(8), .ACC_W(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .appr(appr), .accu(accu), .comp(comp),
    .busy(busy), .done(done), .sum_err(sum_err), .sum_sq(sum_sq),
    .nz_cnt(nz_cnt), .hi_cnt(hi_cnt), .smp_cnt(smp_cnt), .sq_ovf(sq_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int ch, input logic [63:0] e_err,
                        input logic [63:0] e_sq, input logic [31:0] e_nz, input logic [31:0] e_hi);
    chk({tag, "_err"}, sum_err[ch*64 +: 64], e_err);
    chk({tag, "_sq"},  sum_sq[ch*64 +: 64],  MSE ? e_sq : 64'd0);
    chk({tag, "_nz"},  nz_cnt[ch*32 +: 32],  e_nz);
    chk({tag, "_hi"},  hi_cnt[ch*32 +: 32],  e_hi);
  endtask

  task automatic set_in(input logic [31:0] a0, input logic [31:0] u0, input logic [31:0] c0,
                        input logic [31:0] a1, input logic [31:0] u1, input logic [31:0] c1);
    appr = {a1, a0};
    accu = {u1, u0};
    comp = {c1, c0};
  endtask

  task automatic do_start(input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one sample and returns #1 after the edge that accepts it.
  task automatic send;
    int t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_err", sum_err, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero net error on both channels; ch1 operands still differ above bit 8.
    do_start(32'd3);
    chk("t1_busy", busy, 1'b1);
    set_in(32'd100, 32'd100, 32'd0, 32'd1000, 32'd500, -32'sd500);
    send; send; send;
    chk("t1_done0", done, 1'b0);
    @(posedge clk); #1;
    chk("t1_done1", done, 1'b0);
    @(posedge clk); #1;
    chk("t1_done2", done, 1'b1);
    chk("t1_busy_end", busy, 1'b0);
    chk_ch("t1c0", 0, 64'd0, 64'd0, 32'd0, 32'd0);
    chk_ch("t1c1", 1, 64'd0, 64'd0, 32'd0, 32'd3);
    chk("t1_smp", smp_cnt, 32'd3);

    do_start(32'd1);
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd256, 32'd0);
    send;
    wait_done("t2");
    chk_ch("t2c0", 0, 64'd0, 64'd0, 32'd0, 32'd0);
    chk_ch("t2c1", 1, -64'sd256, 64'd65536, 32'd1, 32'd1);
    chk("t2_smp", smp_cnt, 32'd1);

    do_start(32'd0);
    chk("t3_done", done, 1'b1);
    chk("t3_rdy", in_ready, 1'b0);
    chk("t3_err", sum_err, '0);
    chk("t3_nz", nz_cnt, '0);
    chk("t3_hi", hi_cnt, '0);
    chk("t3_smp", smp_cnt, 32'd0);
    idle(2);
    chk("t3_rdy2", in_ready, 1'b0);

    // err = +3 on each channel, valid pattern 1,0,0,1,1,0,1.
    do_start(32'd4);
    set_in(32'd10, 32'd7, 32'd0, 32'd0, 32'd0, 32'd3);
    send; idle(2); send; send; idle(1); send;
    wait_done("t4");
    chk_ch("t4c0", 0, 64'd12, 64'd36, 32'd4, 32'd0);
    chk_ch("t4c1", 1, 64'd12, 64'd36, 32'd4, 32'd0);
    chk("t4_smp", smp_cnt, 32'd4);

    // Gapless rerun, with a start pulse while busy that must be ignored.
    do_start(32'd4);
    start = 1'b1; num_samples = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4b_busy", busy, 1'b1);
    send; send; send; send;
    wait_done("t4b");
    chk_ch("t4bc0", 0, 64'd12, 64'd36, 32'd4, 32'd0);
    chk_ch("t4bc1", 1, 64'd12, 64'd36, 32'd4, 32'd0);
    chk("t4b_smp", smp_cnt, 32'd4);

    // ch0 err=+4, ch1 err=-1 with all high bits differing.
    do_start(32'd5);
    set_in(32'd5, 32'd0, -32'sd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    send; send;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_rdy", in_ready, 1'b0);
    chk("t5_err", sum_err, '0);
    chk("t5_sq", sum_sq, '0);
    chk("t5_nz", nz_cnt, '0);
    chk("t5_hi", hi_cnt, '0);
    chk("t5_smp", smp_cnt, 32'd0);
    chk("t5_ovf", sq_ovf, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    num_samples = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_start", busy, 1'b1);
    repeat (5) send;
    wait_done("t5");
    chk_ch("t5c0", 0, 64'd20, 64'd80, 32'd5, 32'd0);
    chk_ch("t5c1", 1, -64'sd5, 64'd5, 32'd5, 32'd5);
    chk("t5_smp2", smp_cnt, 32'd5);

    // err = 2^32-1; one square fits, the second saturates.
    do_start(32'd2);
    set_in(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0);
    send; send;
    chk("t6_sq1", sum_sq[63:0], MSE ? 64'hFFFF_FFFE_0000_0001 : 64'd0);
    chk("t6_ovf1", sq_ovf, 2'b00);
    wait_done("t6");
    chk_ch("t6c0", 0, 64'h1_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 32'd2);
    chk_ch("t6c1", 1, 64'd0, 64'd0, 32'd0, 32'd0);
    chk("t6_ovf", sq_ovf, MSE ? 2'b01 : 2'b00);
    idle(3);
    chk("t6_hold", sum_err[63:0], 64'h1_FFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
